// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I core definitions: opcodes, func7 codes, forwarding selects
// and the payload record carried by the ID/EX pipeline register.
package id_ex_stage_pkg;

  localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;

  localparam logic [6:0] OPCODE_LOAD  = 7'b000_0011;
  localparam logic [6:0] OPCODE_ITYPE = 7'b001_0011;
  localparam logic [6:0] OPCODE_AUIPC = 7'b001_0111;
  localparam logic [6:0] OPCODE_STORE = 7'b010_0011;
  localparam logic [6:0] OPCODE_RTYPE = 7'b011_0011;
  localparam logic [6:0] OPCODE_LUI   = 7'b011_0111;
  localparam logic [6:0] OPCODE_BTYPE = 7'b110_0011;
  localparam logic [6:0] OPCODE_JALR  = 7'b110_0111;
  localparam logic [6:0] OPCODE_JAL   = 7'b110_1111;

  localparam logic [6:0] FUNC7_NORMAL = 7'b000_0000;
  localparam logic [6:0] FUNC7_ALT    = 7'b010_0000;

  // Where a source operand comes from once hazards are resolved.
  typedef enum logic [1:0] {
    FORWARD_ORG = 2'd0,
    FORWARD_MEM = 2'd1,
    FORWARD_WB  = 2'd2
  } fwd_sel_e;

  // Everything the execute stage needs from one held instruction.
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rs2Data;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rdAddr;
  } ex_payload_t;

  // Only register-register ALU ops and branch compares feed rs2 into the
  // second ALU port; everything else uses the immediate there.
  function automatic logic usesRs2Operand(input logic [6:0] opcode);
    return (opcode == OPCODE_RTYPE) || (opcode == OPCODE_BTYPE);
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// Resolves one source operand against the EX/MEM and MEM/WB producers.
// The younger MEM result wins over WB, and x0 is never forwarded.
module operand_fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [4:0]  srcAddr_i,
  input  logic [31:0] regData_i,
  input  logic        memRegWrite_i,
  input  logic [4:0]  memRdAddr_i,
  input  logic [31:0] memFwdData_i,
  input  logic        wbRegWrite_i,
  input  logic [4:0]  wbRdAddr_i,
  input  logic [31:0] wbFwdData_i,
  output logic [31:0] fwdData_o
);

  fwd_sel_e fwdSel;

  // Pick the operand source, MEM first, never for register x0.
  always_comb begin
    fwdSel = FORWARD_ORG;
    if (memRegWrite_i && (memRdAddr_i == srcAddr_i) && (srcAddr_i != 5'd0)) begin
      fwdSel = FORWARD_MEM;
    end else if (wbRegWrite_i && (wbRdAddr_i == srcAddr_i) && (srcAddr_i != 5'd0)) begin
      fwdSel = FORWARD_WB;
    end
  end

  // Steer the selected value onto the operand.
  always_comb begin
    fwdData_o = regData_i;
    case (fwdSel)
      FORWARD_MEM: fwdData_o = memFwdData_i;
      FORWARD_WB:  fwdData_o = wbFwdData_i;
      default:     fwdData_o = regData_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for an RV32I core. Forwarding is resolved as the
// instruction is captured, so the execute stage sees final operands. The
// stage holds under backpressure and kills its contents on flush.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [4:0]  in_rs1_addr,
  input  logic [4:0]  in_rs2_addr,
  input  logic [4:0]  in_rd_addr,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_func3,
  input  logic [6:0]  in_func7,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_fwd_data,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [31:0] out_rs2_data,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_func3,
  output logic [6:0]  out_func7,
  output logic [4:0]  out_rd_addr
);

  logic        valid_q;
  logic        valid_d;
  ex_payload_t payload_q;
  ex_payload_t payload_d;
  logic [31:0] rs1Fwd;
  logic [31:0] rs2Fwd;
  logic        captureEn;

  operand_fwd_mux u_rs1_fwd (
    .srcAddr_i     (in_rs1_addr),
    .regData_i     (in_rs1_data),
    .memRegWrite_i (mem_reg_write),
    .memRdAddr_i   (mem_rd_addr),
    .memFwdData_i  (mem_fwd_data),
    .wbRegWrite_i  (wb_reg_write),
    .wbRdAddr_i    (wb_rd_addr),
    .wbFwdData_i   (wb_fwd_data),
    .fwdData_o     (rs1Fwd)
  );

  operand_fwd_mux u_rs2_fwd (
    .srcAddr_i     (in_rs2_addr),
    .regData_i     (in_rs2_data),
    .memRegWrite_i (mem_reg_write),
    .memRdAddr_i   (mem_rd_addr),
    .memFwdData_i  (mem_fwd_data),
    .wbRegWrite_i  (wb_reg_write),
    .wbRdAddr_i    (wb_rd_addr),
    .wbFwdData_i   (wb_fwd_data),
    .fwdData_o     (rs2Fwd)
  );

  assign in_ready  = !valid_q || out_ready;
  assign captureEn = in_valid && in_ready && !flush;

  // Next-state: flush kills, capture loads, a drained slot empties, else hold.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (flush) begin
      valid_d          = 1'b0;
      payload_d.opcode = 7'd0;
      payload_d.func3  = 3'd0;
      payload_d.func7  = 7'd0;
    end else if (captureEn) begin
      valid_d           = 1'b1;
      payload_d.op1     = rs1Fwd;
      payload_d.op2     = usesRs2Operand(in_opcode) ? rs2Fwd : in_imm;
      payload_d.rs2Data = rs2Fwd;
      payload_d.pc      = in_pc;
      payload_d.imm     = in_imm;
      payload_d.opcode  = in_opcode;
      payload_d.func3   = in_func3;
      payload_d.func7   = in_func7;
      payload_d.rdAddr  = in_rd_addr;
    end else if (in_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register with synchronous reset clearing every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q           <= 1'b0;
      payload_q.op1     <= ZERO_32BIT;
      payload_q.op2     <= ZERO_32BIT;
      payload_q.rs2Data <= ZERO_32BIT;
      payload_q.pc      <= ZERO_32BIT;
      payload_q.imm     <= ZERO_32BIT;
      payload_q.opcode  <= 7'd0;
      payload_q.func3   <= 3'd0;
      payload_q.func7   <= 7'd0;
      payload_q.rdAddr  <= 5'd0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_op1      = payload_q.op1;
  assign out_op2      = payload_q.op2;
  assign out_rs2_data = payload_q.rs2Data;
  assign out_pc       = payload_q.pc;
  assign out_imm      = payload_q.imm;
  assign out_opcode   = payload_q.opcode;
  assign out_func3    = payload_q.func3;
  assign out_func7    = payload_q.func7;
  assign out_rd_addr  = payload_q.rdAddr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for the ID/EX stage: forwarding, backpressure, flush, reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_fwd_data;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_fwd_data;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_op1, out_op2, out_rs2_data, out_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_func3;
  logic [6:0]  out_func7;
  logic [4:0]  out_rd_addr;

  int asserts  = 0;
  int failures = 0;

  localparam logic [6:0] OP_R = 7'b011_0011;
  localparam logic [6:0] OP_I = 7'b001_0011;
  localparam logic [6:0] OP_S = 7'b010_0011;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_op1(out_op1), .out_op2(out_op2), .out_rs2_data(out_rs2_data),
    .out_pc(out_pc), .out_imm(out_imm), .out_opcode(out_opcode),
    .out_func3(out_func3), .out_func7(out_func7), .out_rd_addr(out_rd_addr)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Present one decoded instruction; hazard inputs are driven separately.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rs1a, input logic [31:0] rs1d,
                               input logic [4:0] rs2a, input logic [31:0] rs2d,
                               input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm);
    in_valid = 1'b1;
    in_opcode = op; in_func3 = f3; in_func7 = f7;
    in_rs1_addr = rs1a; in_rs1_data = rs1d;
    in_rs2_addr = rs2a; in_rs2_data = rs2d;
    in_rd_addr = rd; in_pc = pc; in_imm = imm;
  endtask

  task automatic clearHazards();
    mem_reg_write = 1'b0; mem_rd_addr = 5'd0; mem_fwd_data = 32'h0;
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_fwd_data = 32'h0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    clearHazards();
    applyStimulus(OP_R, 3'd0, 7'd0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h40, 32'h4);
    in_valid = 1'b1;
    stepCycle();
    stepCycle();
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %h expected 0", out_valid); end
    asserts++; if (out_op1 !== 32'h0) begin failures++; $display("[TB] FAIL reset_op1 got %h expected 0", out_op1); end
    asserts++; if (out_opcode !== 7'h0) begin failures++; $display("[TB] FAIL reset_opcode got %h expected 0", out_opcode); end
    asserts++; if (out_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got %h expected 0", out_pc); end
    rst = 1'b0; in_valid = 1'b0;
    stepCycle();
    asserts++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got %h expected 1", in_ready); end
  endtask

  task automatic test_add_no_hazard();
    clearHazards(); out_ready = 1'b1;
    applyStimulus(OP_R, 3'd0, 7'd0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h100, 32'h0);
    stepCycle();
    asserts++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_valid got %h expected 1", out_valid); end
    asserts++; if (out_op1 !== 32'd5) begin failures++; $display("[TB] FAIL add_op1 got %h expected 5", out_op1); end
    asserts++; if (out_op2 !== 32'd7) begin failures++; $display("[TB] FAIL add_op2 got %h expected 7", out_op2); end
    asserts++; if (out_rd_addr !== 5'd3) begin failures++; $display("[TB] FAIL add_rd got %h expected 3", out_rd_addr); end
    asserts++; if (out_pc !== 32'h100) begin failures++; $display("[TB] FAIL add_pc got %h expected 100", out_pc); end
    in_valid = 1'b0;
    stepCycle();
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_valid got %h expected 0", out_valid); end
    asserts++; if (out_op1 !== 32'd5) begin failures++; $display("[TB] FAIL drain_hold_op1 got %h expected 5", out_op1); end
  endtask

  task automatic test_srai_mem_fwd();
    clearHazards(); out_ready = 1'b1;
    mem_reg_write = 1'b1; mem_rd_addr = 5'd1; mem_fwd_data = 32'hF000_0000;
    applyStimulus(OP_I, 3'd5, 7'b010_0000, 5'd1, 32'h8000_0000, 5'd4, 32'h99, 5'd9, 32'h104, 32'h404);
    stepCycle();
    asserts++; if (out_op1 !== 32'hF000_0000) begin failures++; $display("[TB] FAIL srai_op1 got %h expected f0000000", out_op1); end
    asserts++; if (out_op2 !== 32'h404) begin failures++; $display("[TB] FAIL srai_op2 got %h expected 404", out_op2); end
    asserts++; if (out_rs2_data !== 32'h99) begin failures++; $display("[TB] FAIL srai_rs2_data got %h expected 99", out_rs2_data); end
    asserts++; if (out_func7 !== 7'h20) begin failures++; $display("[TB] FAIL srai_func7 got %h expected 20", out_func7); end
    asserts++; if (out_func3 !== 3'd5) begin failures++; $display("[TB] FAIL srai_func3 got %h expected 5", out_func3); end
    in_valid = 1'b0;
    stepCycle();
  endtask

  task automatic test_fwd_priority();
    clearHazards(); out_ready = 1'b1;
    mem_reg_write = 1'b1; mem_rd_addr = 5'd4; mem_fwd_data = 32'h11;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd4; wb_fwd_data = 32'h22;
    applyStimulus(OP_R, 3'd0, 7'd0, 5'd0, 32'hAAAA, 5'd4, 32'h44, 5'd5, 32'h108, 32'h0);
    stepCycle();
    asserts++; if (out_op2 !== 32'h11) begin failures++; $display("[TB] FAIL prio_op2 got %h expected 11", out_op2); end
    asserts++; if (out_rs2_data !== 32'h11) begin failures++; $display("[TB] FAIL prio_rs2_data got %h expected 11", out_rs2_data); end
    mem_rd_addr = 5'd0; mem_fwd_data = 32'h55; wb_rd_addr = 5'd0; wb_fwd_data = 32'h66;
    applyStimulus(OP_R, 3'd0, 7'd0, 5'd0, 32'hAAAA, 5'd4, 32'h44, 5'd5, 32'h10C, 32'h0);
    stepCycle();
    asserts++; if (out_op1 !== 32'hAAAA) begin failures++; $display("[TB] FAIL x0_op1 got %h expected aaaa", out_op1); end
    asserts++; if (out_op2 !== 32'h44) begin failures++; $display("[TB] FAIL x0_op2 got %h expected 44", out_op2); end
    mem_rd_addr = 5'd7; wb_rd_addr = 5'd6; wb_fwd_data = 32'h66;
    applyStimulus(OP_S, 3'd2, 7'd0, 5'd6, 32'h1, 5'd7, 32'h2, 5'd0, 32'h110, 32'h10);
    stepCycle();
    asserts++; if (out_op1 !== 32'h66) begin failures++; $display("[TB] FAIL wb_op1 got %h expected 66", out_op1); end
    asserts++; if (out_op2 !== 32'h10) begin failures++; $display("[TB] FAIL store_op2 got %h expected 10", out_op2); end
    asserts++; if (out_rs2_data !== 32'h55) begin failures++; $display("[TB] FAIL store_rs2_data got %h expected 55", out_rs2_data); end
    in_valid = 1'b0; clearHazards();
    stepCycle();
  endtask

  task automatic test_backpressure();
    clearHazards(); out_ready = 1'b1;
    applyStimulus(OP_R, 3'd0, 7'd0, 5'd5, 32'h100, 5'd6, 32'h200, 5'd7, 32'h200, 32'h0);
    stepCycle();
    out_ready = 1'b0;
    mem_reg_write = 1'b1; mem_rd_addr = 5'd5; mem_fwd_data = 32'hDEAD;
    applyStimulus(OP_R, 3'd0, 7'd0, 5'd5, 32'h300, 5'd6, 32'h400, 5'd8, 32'h204, 32'h0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      asserts++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL hold_in_ready cycle %0d got %h expected 0", i, in_ready); end
      asserts++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL hold_valid cycle %0d got %h expected 1", i, out_valid); end
      asserts++; if (out_op1 !== 32'h100) begin failures++; $display("[TB] FAIL hold_op1 cycle %0d got %h expected 100", i, out_op1); end
      asserts++; if (out_rd_addr !== 5'd7) begin failures++; $display("[TB] FAIL hold_rd cycle %0d got %h expected 7", i, out_rd_addr); end
    end
    clearHazards(); out_ready = 1'b1;
    #1;
    asserts++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready got %h expected 1", in_ready); end
    stepCycle();
    asserts++; if (out_op1 !== 32'h300) begin failures++; $display("[TB] FAIL release_op1 got %h expected 300", out_op1); end
    asserts++; if (out_op2 !== 32'h400) begin failures++; $display("[TB] FAIL release_op2 got %h expected 400", out_op2); end
    asserts++; if (out_rd_addr !== 5'd8) begin failures++; $display("[TB] FAIL release_rd got %h expected 8", out_rd_addr); end
    in_valid = 1'b0;
    stepCycle();
  endtask

  task automatic test_back_to_back();
    clearHazards(); out_ready = 1'b1;
    applyStimulus(OP_R, 3'd0, 7'd0, 5'd1, 32'hA1, 5'd2, 32'hB1, 5'd10, 32'h300, 32'h0);
    stepCycle();
    applyStimulus(OP_R, 3'd0, 7'd0, 5'd1, 32'hA2, 5'd2, 32'hB2, 5'd11, 32'h304, 32'h0);
    stepCycle();
    asserts++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid got %h expected 1", out_valid); end
    asserts++; if (out_op1 !== 32'hA2) begin failures++; $display("[TB] FAIL b2b_op1 got %h expected a2", out_op1); end
    asserts++; if (out_pc !== 32'h304) begin failures++; $display("[TB] FAIL b2b_pc got %h expected 304", out_pc); end
    in_valid = 1'b0;
    stepCycle();
  endtask

  task automatic test_flush();
    clearHazards(); out_ready = 1'b1;
    applyStimulus(OP_R, 3'd0, 7'd0, 5'd1, 32'h77, 5'd2, 32'h88, 5'd12, 32'h400, 32'h0);
    stepCycle();
    flush = 1'b1;
    applyStimulus(OP_R, 3'd5, 7'b010_0000, 5'd1, 32'h123, 5'd2, 32'h456, 5'd13, 32'h404, 32'h0);
    stepCycle();
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got %h expected 0", out_valid); end
    asserts++; if (out_opcode !== 7'h0) begin failures++; $display("[TB] FAIL flush_opcode got %h expected 0", out_opcode); end
    asserts++; if (out_func3 !== 3'h0) begin failures++; $display("[TB] FAIL flush_func3 got %h expected 0", out_func3); end
    asserts++; if (out_func7 !== 7'h0) begin failures++; $display("[TB] FAIL flush_func7 got %h expected 0", out_func7); end
    asserts++; if (out_op1 !== 32'h77) begin failures++; $display("[TB] FAIL flush_op1 got %h expected 77", out_op1); end
    flush = 1'b0; in_valid = 1'b0;
    stepCycle();
  endtask

  task automatic test_reset_during_hold();
    clearHazards(); out_ready = 1'b1;
    applyStimulus(OP_I, 3'd1, 7'd0, 5'd3, 32'h333, 5'd4, 32'h444, 5'd14, 32'h500, 32'h8);
    stepCycle();
    out_ready = 1'b0;
    stepCycle();
    rst = 1'b1;
    stepCycle();
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rsthold_valid got %h expected 0", out_valid); end
    asserts++; if (out_op1 !== 32'h0) begin failures++; $display("[TB] FAIL rsthold_op1 got %h expected 0", out_op1); end
    asserts++; if (out_op2 !== 32'h0) begin failures++; $display("[TB] FAIL rsthold_op2 got %h expected 0", out_op2); end
    asserts++; if (out_rs2_data !== 32'h0) begin failures++; $display("[TB] FAIL rsthold_rs2_data got %h expected 0", out_rs2_data); end
    asserts++; if (out_imm !== 32'h0) begin failures++; $display("[TB] FAIL rsthold_imm got %h expected 0", out_imm); end
    asserts++; if (out_func3 !== 3'h0) begin failures++; $display("[TB] FAIL rsthold_func3 got %h expected 0", out_func3); end
    asserts++; if (out_rd_addr !== 5'h0) begin failures++; $display("[TB] FAIL rsthold_rd got %h expected 0", out_rd_addr); end
    rst = 1'b0; in_valid = 1'b0;
    stepCycle();
    asserts++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rsthold_in_ready got %h expected 1", in_ready); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_add_no_hazard();
    test_srai_mem_fwd();
    test_fwd_priority();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_during_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
